// File: rtl/clock_seq_pkg.sv
// ============================================================================
// clock_seq_pkg : shared types and constants for the clock enable sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package clock_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } seq_state_t;

    localparam int unsigned DEFAULT_GAP = 0;

endpackage

`default_nettype wire

// File: rtl/seq_gap_counter.sv
// ============================================================================
// seq_gap_counter : loadable down-counter, expired while the count sits at 0
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_gap_counter #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [GAP_W-1:0] value_i,
    output logic             expired_o
);

    logic [GAP_W-1:0] count;

    // Saturates at zero so a full-scale gap never wraps early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_i) begin
            count <= value_i;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired_o = (count == '0);

endmodule

`default_nettype wire

// File: rtl/clock_enable_sequencer.sv
// ============================================================================
// clock_enable_sequencer : ordered power-up / power-down of clock enables
// Revision 1.0
// ============================================================================
`default_nettype none

module clock_enable_sequencer
    import clock_seq_pkg::*;
#(
    parameter int NUM_CLK = 4,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [GAP_W-1:0]   gap_i,
    output logic [NUM_CLK-1:0] enable_o,
    output logic               busy_o,
    output logic               running_o,
    output logic               up_done_o,
    output logic               down_done_o
);

    localparam int IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    seq_state_t         state,     state_n;
    logic [IDX_W-1:0]   idx,       idx_n;
    logic [GAP_W-1:0]   gap_q,     gap_n;
    logic [NUM_CLK-1:0] enable_q,  enable_n;
    logic               busy_q,    busy_n;
    logic               running_q, running_n;
    logic               up_done_q, up_done_n;
    logic               down_done_q, down_done_n;
    logic               last_step;
    logic               cnt_load;
    logic [GAP_W-1:0]   cnt_value;
    logic               cnt_expired;

    seq_gap_counter #(
        .GAP_W (GAP_W)
    ) u_gap_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .value_i   (cnt_value),
        .expired_o (cnt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            gap_q       <= '0;
            enable_q    <= '0;
            busy_q      <= 1'b0;
            running_q   <= 1'b0;
            up_done_q   <= 1'b0;
            down_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            gap_q       <= gap_n;
            enable_q    <= enable_n;
            busy_q      <= busy_n;
            running_q   <= running_n;
            up_done_q   <= up_done_n;
            down_done_q <= down_done_n;
        end
    end

    // Accepting a request loads a zero gap so the first step lands on the next edge.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        gap_n       = gap_q;
        enable_n    = enable_q;
        busy_n      = busy_q;
        running_n   = running_q;
        up_done_n   = 1'b0;
        down_done_n = 1'b0;
        last_step   = 1'b0;
        cnt_load    = 1'b0;
        cnt_value   = gap_q;

        case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_n   = RAMP_UP;
                    gap_n     = gap_i;
                    idx_n     = '0;
                    cnt_load  = 1'b1;
                    cnt_value = GAP_W'(DEFAULT_GAP);
                end
            end
            RAMP_UP: begin
                if (stop_i) begin
                    state_n   = RAMP_DOWN;
                    gap_n     = gap_i;
                    cnt_load  = 1'b1;
                    cnt_value = GAP_W'(DEFAULT_GAP);
                end else if (cnt_expired) begin
                    if (!enable_q[0]) begin
                        enable_n[0] = 1'b1;
                        last_step   = (NUM_CLK == 1);
                    end else begin
                        idx_n           = idx + 1'b1;
                        enable_n[idx_n] = 1'b1;
                        last_step       = (idx_n == IDX_W'(NUM_CLK - 1));
                    end
                    if (last_step) begin
                        state_n   = ON;
                        busy_n    = 1'b0;
                        running_n = 1'b1;
                        up_done_n = 1'b1;
                    end else begin
                        busy_n   = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            ON: begin
                if (stop_i) begin
                    state_n   = RAMP_DOWN;
                    gap_n     = gap_i;
                    cnt_load  = 1'b1;
                    cnt_value = GAP_W'(DEFAULT_GAP);
                end
            end
            RAMP_DOWN: begin
                if (cnt_expired) begin
                    enable_n[idx] = 1'b0;
                    running_n     = 1'b0;
                    if (idx == '0) begin
                        state_n     = IDLE;
                        busy_n      = 1'b0;
                        down_done_n = 1'b1;
                    end else begin
                        idx_n    = idx - 1'b1;
                        busy_n   = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign enable_o    = enable_q;
    assign busy_o      = busy_q;
    assign running_o   = running_q;
    assign up_done_o   = up_done_q;
    assign down_done_o = down_done_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_enable_sequencer.sv
// ============================================================================
// tb_clock_enable_sequencer : directed bench for clock_enable_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_clock_enable_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, stop_i;
    logic [7:0] gap_i;
    logic [3:0] enable_o;
    logic       busy_o, running_o, up_done_o, down_done_o;

    logic       start2, stop2;
    logic [7:0] gap2;
    logic [1:0] enable2;
    logic       busy2, running2, up_done2, down_done2;

    int n_cmp  = 0;
    int n_err  = 0;
    int up_cnt = 0;
    int dn_cnt = 0;

    always #5 clk = ~clk;

    clock_enable_sequencer #(.NUM_CLK(4), .GAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .gap_i(gap_i),
        .enable_o(enable_o), .busy_o(busy_o), .running_o(running_o),
        .up_done_o(up_done_o), .down_done_o(down_done_o)
    );

    clock_enable_sequencer #(.NUM_CLK(2), .GAP_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .stop_i(stop2), .gap_i(gap2),
        .enable_o(enable2), .busy_o(busy2), .running_o(running2),
        .up_done_o(up_done2), .down_done_o(down_done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic thermo(input logic [15:0] v);
        return ((v & (v + 16'd1)) == 16'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("thermo", {31'd0, thermo(16'(enable_o))}, 32'd1);
            check("thermo2", {31'd0, thermo(16'(enable2))}, 32'd1);
            if (up_done_o)   up_cnt++;
            if (down_done_o) dn_cnt++;
        end
    end

    task automatic ramp_up_check(input int gap);
        int last, n;
        last    = 1 + 3 * (gap + 1);
        gap_i   = 8'(gap);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        gap_i   = 8'hA5;
        check("up_accept_en", 32'(enable_o), 32'd0);
        check("up_accept_busy", 32'(busy_o), 32'd0);
        for (int k = 1; k <= last + 1; k++) begin
            tick();
            n = 1 + (k - 1) / (gap + 1);
            if (n > 4) n = 4;
            check("up_en", 32'(enable_o), 32'((1 << n) - 1));
            check("up_busy", 32'(busy_o), 32'(k < last));
            check("up_running", 32'(running_o), 32'(k >= last));
            check("up_done", 32'(up_done_o), 32'(k == last));
        end
    endtask

    task automatic ramp_down_check(input int gap);
        int last, n;
        last   = 1 + 3 * (gap + 1);
        gap_i  = 8'(gap);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        gap_i  = 8'h7F;
        check("dn_accept_en", 32'(enable_o), 32'hF);
        check("dn_accept_running", 32'(running_o), 32'd1);
        for (int k = 1; k <= last + 1; k++) begin
            tick();
            n = (k >= last) ? 0 : 3 - (k - 1) / (gap + 1);
            check("dn_en", 32'(enable_o), 32'((1 << n) - 1));
            check("dn_running", 32'(running_o), 32'd0);
            check("dn_busy", 32'(busy_o), 32'(k < last));
            check("dn_done", 32'(down_done_o), 32'(k == last));
        end
    endtask

    initial begin
        int up0, dn0;
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; gap_i = 8'd0;
        start2 = 1'b0; stop2 = 1'b0; gap2 = 8'd0;
        repeat (3) tick();
        check("rst_en", 32'(enable_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_en", 32'(enable_o), 32'd0);
        check("idle_running", 32'(running_o), 32'd0);
        check("idle_pulses", {30'd0, up_done_o, down_done_o}, 32'd0);

        // Power-up with gap 3, then a start request while ON must be ignored.
        ramp_up_check(3);
        start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("on_ignore_en", 32'(enable_o), 32'hF);
            check("on_ignore_busy", 32'(busy_o), 32'd0);
            check("on_ignore_running", 32'(running_o), 32'd1);
        end
        start_i = 1'b0;
        ramp_down_check(0);

        // Simultaneous start and stop in IDLE.
        up0 = up_cnt; dn0 = dn_cnt;
        start_i = 1'b1; stop_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("both_en", 32'(enable_o), 32'd0);
            check("both_busy", 32'(busy_o), 32'd0);
        end
        start_i = 1'b0; stop_i = 1'b0;
        tick();
        check("both_up_pulses", 32'(up_cnt - up0), 32'd0);
        check("both_dn_pulses", 32'(dn_cnt - dn0), 32'd0);

        // Abort: gap 5, stop accepted while enable_o = 0011.
        up0 = up_cnt;
        gap_i = 8'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("abort_up_en", 32'(enable_o), (k < 7) ? 32'h1 : 32'h3);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        gap_i  = 8'd0;
        check("abort_accept_en", 32'(enable_o), 32'h3);
        for (int k = 9; k <= 16; k++) begin
            tick();
            check("abort_dn_en", 32'(enable_o), (k < 15) ? 32'h1 : 32'h0);
            check("abort_busy", 32'(busy_o), 32'(k < 15));
            check("abort_dn_done", 32'(down_done_o), 32'(k == 15));
        end
        check("abort_no_up_done", 32'(up_cnt - up0), 32'd0);

        // Asynchronous reset in the middle of a ramp.
        gap_i = 8'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        check("mid_en_before_rst", 32'(enable_o), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en_async", 32'(enable_o), 32'h0);
        check("mid_rst_busy_async", 32'(busy_o), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_en", 32'(enable_o), 32'h0);
        check("post_rst_running", 32'(running_o), 32'd0);
        ramp_up_check(3);
        ramp_down_check(0);

        // Full-scale gap on the two-clock instance.
        gap2 = 8'd255; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        gap2   = 8'd0;
        check("g255_accept_en", 32'(enable2), 32'd0);
        for (int k = 1; k <= 258; k++) begin
            tick();
            check("g255_en", 32'(enable2), (k < 257) ? 32'h1 : 32'h3);
            check("g255_up_done", 32'(up_done2), 32'(k == 257));
        end
        check("g255_running", 32'(running2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
